// File: rtl/cmp_minmax_tracker.sv
// Streaming min/max tracker: accepts a frame of 4-bit samples over valid/ready and reports
// the frame maximum/minimum, their first-occurrence indices, a saturating sample count and done.

module cmp_minmax_cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       greator
);
  assign greator = (a > b);
endmodule

module cmp_minmax_tracker #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_last,
  output logic [3:0]       max_val,
  output logic [3:0]       min_val,
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] min_idx,
  output logic [CNT_W-1:0] count,
  output logic             cnt_ovf,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       max_reg, max_next;
  logic [3:0]       min_reg, min_next;
  logic [CNT_W-1:0] max_idx_reg, max_idx_next;
  logic [CNT_W-1:0] min_idx_reg, min_idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             accept;

  // Instance 0 flags a new maximum (in_data > max); instance 1 a new minimum (min > in_data).
  // Ties raise neither flag, so the earliest index of an equal value is kept.
  logic [3:0] cmp_a [2];
  logic [3:0] cmp_b [2];
  logic [1:0] upd;

  assign cmp_a[0] = in_data;
  assign cmp_b[0] = max_reg;
  assign cmp_a[1] = min_reg;
  assign cmp_b[1] = in_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
      cmp_minmax_cmp4 u_cmp (
        .a       (cmp_a[gi]),
        .b       (cmp_b[gi]),
        .greator (upd[gi])
      );
    end
  endgenerate

  assign in_ready = ((state_reg == FIRST) || (state_reg == RUN)) && !start;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      max_reg     <= '0;
      min_reg     <= '0;
      max_idx_reg <= '0;
      min_idx_reg <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      max_reg     <= max_next;
      min_reg     <= min_next;
      max_idx_reg <= max_idx_next;
      min_idx_reg <= min_idx_next;
      cnt_reg     <= cnt_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    max_next     = max_reg;
    min_next     = min_reg;
    max_idx_next = max_idx_reg;
    min_idx_next = min_idx_reg;
    cnt_next     = cnt_reg;
    ovf_next     = ovf_reg;

    if (start) begin
      // Restart from any state; in_ready is low, so no sample is taken this cycle.
      state_next   = FIRST;
      max_idx_next = '0;
      min_idx_next = '0;
      cnt_next     = '0;
      ovf_next     = 1'b0;
    end else if (accept) begin
      if (state_reg == FIRST) begin
        max_next     = in_data;
        min_next     = in_data;
        max_idx_next = '0;
        min_idx_next = '0;
        cnt_next     = CNT_W'(1);
      end else begin
        // cnt_reg is this sample's index, already saturated once the counter is full.
        if (upd[0]) begin
          max_next     = in_data;
          max_idx_next = cnt_reg;
        end
        if (upd[1]) begin
          min_next     = in_data;
          min_idx_next = cnt_reg;
        end
        if (cnt_reg == CNT_MAX) begin
          ovf_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      state_next = in_last ? DONE : RUN;
    end
  end

  assign max_val = max_reg;
  assign min_val = min_reg;
  assign max_idx = max_idx_reg;
  assign min_idx = min_idx_reg;
  assign count   = cnt_reg;
  assign cnt_ovf = ovf_reg;
  assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// Bench for cmp_minmax_tracker: two widths (CNT_W=4 and CNT_W=3) share one stimulus stream and
// are checked every cycle against a frame-level model, plus hand-computed literal expectations.
module tb_cmp_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start, in_valid, in_last;
  logic [3:0] in_data;

  logic       in_ready4, cnt_ovf4, done4;
  logic [3:0] max_val4, min_val4, max_idx4, min_idx4, count4;
  logic       in_ready3, cnt_ovf3, done3;
  logic [3:0] max_val3, min_val3;
  logic [2:0] max_idx3, min_idx3, count3;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model: samples accepted in the current frame, and frame status.
  int q[$];
  bit m_active, m_done, m_started;

  always #5 clk = ~clk;

  cmp_minmax_tracker #(.CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_last(in_last), .max_val(max_val4), .min_val(min_val4),
    .max_idx(max_idx4), .min_idx(min_idx4), .count(count4), .cnt_ovf(cnt_ovf4), .done(done4)
  );

  cmp_minmax_tracker #(.CNT_W(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_last(in_last), .max_val(max_val3), .min_val(min_val3),
    .max_idx(max_idx3), .min_idx(min_idx3), .count(count3), .cnt_ovf(cnt_ovf3), .done(done3)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active  = 1'b0;
    m_done    = 1'b0;
    m_started = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    if (!rst_n) return;
    acc = in_valid && m_active && !start;
    if (start) begin
      q.delete();
      m_active  = 1'b1;
      m_done    = 1'b0;
      m_started = 1'b1;
    end else if (acc) begin
      q.push_back(int'(in_data));
      if (in_last) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic check_dut(input string tag, input int lim,
                           input logic [3:0] mx, input logic [3:0] mn,
                           input logic [3:0] mxi, input logic [3:0] mni,
                           input logic [3:0] cnt, input logic ovf,
                           input logic dn, input logic rdy);
    int n, emx, emn, emxi, emni;
    n = q.size();
    emx = 0; emn = 0; emxi = 0; emni = 0;
    if (n > 0) begin
      emx = q[0];
      emn = q[0];
      foreach (q[k]) begin
        if (q[k] > emx) emx = q[k];
        if (q[k] < emn) emn = q[k];
      end
      emxi = -1;
      emni = -1;
      foreach (q[k]) begin
        if (emxi < 0 && q[k] == emx) emxi = k;
        if (emni < 0 && q[k] == emn) emni = k;
      end
    end
    // Right after a start, before the first sample, the value outputs carry no frame data.
    if (!(m_started && n == 0)) begin
      chk({tag, "_max_val"}, 16'(mx), 16'(emx));
      chk({tag, "_min_val"}, 16'(mn), 16'(emn));
    end
    chk({tag, "_max_idx"}, 16'(mxi), 16'(sat(emxi, lim)));
    chk({tag, "_min_idx"}, 16'(mni), 16'(sat(emni, lim)));
    chk({tag, "_count"},   16'(cnt), 16'(sat(n, lim)));
    chk({tag, "_cnt_ovf"}, 16'(ovf), 16'(n > lim));
    chk({tag, "_done"},    16'(dn),  16'(m_done));
    chk({tag, "_in_ready"}, 16'(rdy), 16'(m_active && !start));
  endtask

  always @(negedge clk) begin
    check_dut("w4", 15, max_val4, min_val4, max_idx4, min_idx4, count4, cnt_ovf4, done4, in_ready4);
    check_dut("w3", 7, max_val3, min_val3, {1'b0, max_idx3}, {1'b0, min_idx3}, {1'b0, count3},
              cnt_ovf3, done3, in_ready3);
  end

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input int d, input bit last);
    in_valid = 1'b1;
    in_data  = 4'(d);
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    start = 0; in_valid = 0; in_last = 0; in_data = 0;
    model_reset();
    repeat (2) step();
    chk("rst_max_val", 16'(max_val4), 0);
    chk("rst_count", 16'(count4), 0);
    chk("rst_done", 16'(done4), 0);
    chk("rst_in_ready", 16'(in_ready4), 0);
    rst_n = 1'b1;
    step();

    // Frame 5,9,2,9,2: ties keep earliest index.
    pulse_start();
    send(5, 0); send(9, 0); send(2, 0); send(9, 0);
    chk("t1_done_early", 16'(done4), 0);
    send(2, 1);
    chk("t1_max_val", 16'(max_val4), 9);
    chk("t1_max_idx", 16'(max_idx4), 1);
    chk("t1_min_val", 16'(min_val4), 2);
    chk("t1_min_idx", 16'(min_idx4), 2);
    chk("t1_count", 16'(count4), 5);
    chk("t1_done", 16'(done4), 1);
    in_valid = 1'b1; in_data = 4'hf;
    repeat (2) step();
    in_valid = 1'b0;
    chk("t1_done_hold_count", 16'(count4), 5);

    // Single-sample frame.
    pulse_start();
    send(7, 1);
    chk("t2_max_val", 16'(max_val4), 7);
    chk("t2_min_val", 16'(min_val3), 7);
    chk("t2_idx", 16'({max_idx4, min_idx4}), 0);
    chk("t2_count", 16'(count4), 1);
    chk("t2_done", 16'(done4), 1);

    // Gaps between samples.
    pulse_start();
    send(3, 0); repeat (2) step();
    send(15, 0); repeat (2) step();
    send(0, 1);
    chk("t3_max", 16'({max_val4, max_idx4}), 16'h0f1);
    chk("t3_min", 16'({min_val4, min_idx4}), 16'h002);
    chk("t3_count", 16'(count4), 3);

    // Restart mid-frame; the sample offered with start is dropped.
    pulse_start();
    send(4, 0); send(8, 0);
    start = 1'b1; in_valid = 1'b1; in_data = 4'd6;
    step();
    start = 1'b0; in_valid = 1'b0;
    send(1, 0); send(2, 1);
    chk("t4_max", 16'({max_val4, max_idx4}), 16'h021);
    chk("t4_min", 16'({min_val4, min_idx4}), 16'h010);
    chk("t4_count", 16'(count4), 2);

    // Counter saturation: 9 samples 0..8.
    pulse_start();
    for (int i = 0; i < 9; i++) send(i, i == 8);
    chk("t5_w3_count", 16'(count3), 7);
    chk("t5_w3_ovf", 16'(cnt_ovf3), 1);
    chk("t5_w3_max", 16'({max_val3, 1'b0, max_idx3}), 16'h087);
    chk("t5_w3_min", 16'({min_val3, 1'b0, min_idx3}), 16'h000);
    chk("t5_w4_count", 16'(count4), 9);
    chk("t5_w4_ovf", 16'(cnt_ovf4), 0);
    chk("t5_w4_max_idx", 16'(max_idx4), 8);

    // Asynchronous reset between clock edges, mid-frame.
    pulse_start();
    send(3, 0); send(5, 0);
    in_valid = 1'b1; in_data = 4'hc;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_max_val", 16'(max_val4), 0);
    chk("t6_min_val", 16'(min_val3), 0);
    chk("t6_count", 16'(count4), 0);
    chk("t6_max_idx", 16'(max_idx4), 0);
    chk("t6_in_ready", 16'(in_ready4), 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) step();
    chk("t6_idle_ready", 16'(in_ready4), 0);
    chk("t6_idle_count", 16'(count4), 0);
    in_valid = 1'b0;
    pulse_start();
    send(11, 1);
    chk("t6_after_max", 16'({max_val4, min_val4}), 16'h0bb);
    chk("t6_after_count", 16'(count4), 1);
    chk("t6_after_done", 16'(done4), 1);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
